// File: rtl/tpu_mm_master.sv
// tpu_mm_master: Avalon-MM burst sequencer with credit-limited pipelined reads and a read-return FIFO
module tpu_mm_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int RD_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic                    wdata_valid,
  output logic                    wdata_ready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic                    rdata_valid,
  input  logic                    rdata_ready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH-1:0]   master_address,
  output logic                    master_read,
  output logic                    master_write,
  output logic [DATA_WIDTH-1:0]   master_writedata,
  output logic [DATA_WIDTH/8-1:0] master_byteenable,
  input  logic                    master_waitrequest,
  input  logic [DATA_WIDTH-1:0]   master_readdata,
  input  logic                    master_readdatavalid
);
  localparam int PW = $clog2(RD_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(RD_DEPTH);
  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_inc;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;
  logic mwrite_q, mwrite_d, done_q, done_d;
  logic [8:0] fetch_q, fetch_d, left_q, left_d;
  logic [CW-1:0] outst_q, outst_d, cnt_q, cnt_d;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [DATA_WIDTH-1:0] mem_q [RD_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [RD_DEPTH];
  logic accept, wr_xfer, rd_xfer, push, pop;
  assign cmd_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign master_address = addr_q;
  assign master_write = mwrite_q;
  assign master_writedata = wd_q;
  assign master_byteenable = '1;
  assign rdata_valid = cnt_q != '0;
  assign rdata = mem_q[rp_q];
  assign wdata_ready = state_q == WRITE && fetch_q != '0 && (!mwrite_q || !master_waitrequest);
  assign master_read = state_q == READ && left_q != '0 && (outst_q + cnt_q) < DEPTH;
  assign accept = wdata_valid && wdata_ready;
  assign wr_xfer = mwrite_q && !master_waitrequest;
  assign rd_xfer = master_read && !master_waitrequest;
  assign push = master_readdatavalid && outst_q != '0;
  assign pop = rdata_valid && rdata_ready;
  assign addr_inc = {addr_q[ADDR_WIDTH-1:8], addr_q[7:0] + 8'd1};
  always_comb begin
    state_d = state_q;
    addr_d = (wr_xfer || rd_xfer) ? addr_inc : addr_q;
    left_d = (wr_xfer || rd_xfer) ? left_q - 9'd1 : left_q;
    fetch_d = accept ? fetch_q - 9'd1 : fetch_q;
    wd_d = accept ? wdata : wd_q;
    mwrite_d = accept || (mwrite_q && master_waitrequest);
    outst_d = outst_q + CW'(rd_xfer) - CW'(push);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    wp_d = wp_q + PW'(push);
    rp_d = rp_q + PW'(pop);
    mem_d = mem_q;
    if (push) mem_d[wp_q] = master_readdata;
    if (state_q == IDLE && cmd_valid) begin
      state_d = cmd_write ? WRITE : READ;
      addr_d = cmd_addr;
      fetch_d = {1'b0, cmd_len} + 9'd1;
      left_d = {1'b0, cmd_len} + 9'd1;
    end
    if ((wr_xfer || rd_xfer) && left_q == 9'd1) state_d = wr_xfer ? IDLE : DRAIN;
    if (state_q == DRAIN && outst_d == '0) state_d = IDLE;
    done_d = (wr_xfer && left_q == 9'd1) || (state_q == DRAIN && outst_d == '0);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      wd_q <= '0;
      mwrite_q <= 1'b0;
      done_q <= 1'b0;
      fetch_q <= '0;
      left_q <= '0;
      outst_q <= '0;
      cnt_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wd_q <= wd_d;
      mwrite_q <= mwrite_d;
      done_q <= done_d;
      fetch_q <= fetch_d;
      left_q <= left_d;
      outst_q <= outst_d;
      cnt_q <= cnt_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      mem_q <= mem_d;
    end
  end
endmodule
